siso_stream_gen: RTL and testbench

Stimulus-side counterpart of the SISO decoder input port. Accepts information bits with per-bit a-priori LLRs. Runs them through the 8-state constituent RSC encoder with trellis termination. Emits the decoder's input stream: one 16-bit LLR sample per cycle (systematic, then parity, per trellis step), plus an a-priori word flagged with `valid_apriori` on each systematic sample. It closes the loop for self-checking decoder benches and feeds the decoder `top` directly in hardware loopback.

---
 rtl/siso_pkg.sv | 24 ++
 rtl/siso_stream_gen_rsc_encoder.sv | 39 +++
 rtl/siso_stream_gen.sv | 164 ++++++++++++++++
 tb/tb_siso_stream_gen.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/siso_pkg.sv
// Shared types and helpers for the SISO decoder stimulus generator.
// Holds the stream FSM encoding and the bit-to-LLR mapping.
package siso_pkg;

  localparam int DATA_W   = 16;
  localparam int BLKLEN_W = 13;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    D_SYS = 3'd1,
    D_PAR = 3'd2,
    T_SYS = 3'd3,
    T_PAR = 3'd4,
    FIN   = 3'd5
  } state_e;

  // bit 0 -> +amp, bit 1 -> -amp (two's complement)
  function automatic logic [DATA_W-1:0] llr_map(input logic b, input int amp);
    logic [DATA_W-1:0] v;
    v = DATA_W'(amp);
    return b ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/siso_stream_gen_rsc_encoder.sv
// 8-state recursive systematic convolutional encoder core.
// State is {s1,s2,s3}; the tail input forces the feedback to zero.
module rsc_encoder (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic step,
  input  logic tail,
  input  logic u,
  output logic z,
  output logic tail_u
);

  logic [2:0] s_q, s_d;
  logic       u_eff;
  logic       a;

  always_comb begin
    tail_u = s_q[1] ^ s_q[0];
    u_eff  = tail ? tail_u : u;
    a      = u_eff ^ s_q[1] ^ s_q[0];
    z      = a ^ s_q[2] ^ s_q[0];
    s_d    = s_q;
    if (clear) begin
      s_d = 3'b000;
    end else if (step || tail) begin
      s_d = {a, s_q[2], s_q[1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= 3'b000;
    end else begin
      s_q <= s_d;
    end
  end

endmodule

// File: rtl/siso_stream_gen.sv
// Turns information bits plus a-priori LLRs into the decoder input stream:
// systematic/parity LLR pairs per trellis step, followed by 3 termination steps.
//
// state | meaning
// IDLE  | waiting for start
// D_SYS | accept one info bit, emit its systematic sample
// D_PAR | emit the parity of the bit just accepted
// T_SYS | emit a tail systematic sample (a-priori forced to 0)
// T_PAR | emit a tail parity sample
// FIN   | one-cycle done pulse
module siso_stream_gen #(
  parameter int DATA_W     = 16,
  parameter int AMP        = 1024,
  parameter int MAX_BLKLEN = 6144
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [siso_pkg::BLKLEN_W-1:0] blklen,
  input  logic                          bit_in,
  input  logic [DATA_W-1:0]             apriori_in,
  input  logic                          bit_valid,
  output logic                          bit_ready,
  output logic [DATA_W-1:0]             out,
  output logic                          valid_out,
  output logic [DATA_W-1:0]             apriori,
  output logic                          valid_apriori,
  output logic                          idle,
  output logic                          done
);

  import siso_pkg::*;

  state_e                state_q, state_d;
  logic [BLKLEN_W-1:0]   k_q, k_d;
  logic [BLKLEN_W-1:0]   cnt_q, cnt_d;
  logic [BLKLEN_W-1:0]   k_sel;
  logic [1:0]            tcnt_q, tcnt_d;
  logic                  z_q, z_d;
  logic [DATA_W-1:0]     out_q, out_d;
  logic [DATA_W-1:0]     apriori_q, apriori_d;
  logic                  valid_out_q, valid_out_d;
  logic                  valid_ap_q, valid_ap_d;
  logic                  done_q, done_d;

  logic enc_clear, enc_step, enc_tail;
  logic enc_z, enc_tail_u;

  // Encoder controls are decoded straight from state so the FSM block never
  // feeds back into the encoder's combinational outputs.
  assign enc_clear = (state_q == IDLE) && start;
  assign enc_step  = (state_q == D_SYS) && bit_valid;
  assign enc_tail  = (state_q == T_SYS);

  rsc_encoder u_enc (
    .clk    (clk),
    .rst    (rst),
    .clear  (enc_clear),
    .step   (enc_step),
    .tail   (enc_tail),
    .u      (bit_in),
    .z      (enc_z),
    .tail_u (enc_tail_u)
  );

  assign k_sel = (blklen > BLKLEN_W'(MAX_BLKLEN)) ? BLKLEN_W'(MAX_BLKLEN) : blklen;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    tcnt_d      = tcnt_q;
    z_d         = z_q;
    out_d       = out_q;
    apriori_d   = apriori_q;
    valid_out_d = 1'b0;
    valid_ap_d  = 1'b0;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          k_d     = k_sel;
          cnt_d   = '0;
          tcnt_d  = 2'd0;
          state_d = (k_sel == '0) ? T_SYS : D_SYS;
        end
      end
      D_SYS: begin
        if (bit_valid) begin
          out_d       = DATA_W'(llr_map(bit_in, AMP));
          valid_out_d = 1'b1;
          apriori_d   = apriori_in;
          valid_ap_d  = 1'b1;
          z_d         = enc_z;
          state_d     = D_PAR;
        end
      end
      D_PAR: begin
        out_d       = DATA_W'(llr_map(z_q, AMP));
        valid_out_d = 1'b1;
        cnt_d       = cnt_q + 1'b1;
        state_d     = (cnt_q == k_q - 1'b1) ? T_SYS : D_SYS;
      end
      T_SYS: begin
        out_d       = DATA_W'(llr_map(enc_tail_u, AMP));
        valid_out_d = 1'b1;
        apriori_d   = '0;
        valid_ap_d  = 1'b1;
        z_d         = enc_z;
        state_d     = T_PAR;
      end
      T_PAR: begin
        out_d       = DATA_W'(llr_map(z_q, AMP));
        valid_out_d = 1'b1;
        if (tcnt_q == 2'd2) begin
          state_d = FIN;
        end else begin
          tcnt_d  = tcnt_q + 2'd1;
          state_d = T_SYS;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      cnt_q       <= '0;
      tcnt_q      <= 2'd0;
      z_q         <= 1'b0;
      out_q       <= '0;
      apriori_q   <= '0;
      valid_out_q <= 1'b0;
      valid_ap_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      tcnt_q      <= tcnt_d;
      z_q         <= z_d;
      out_q       <= out_d;
      apriori_q   <= apriori_d;
      valid_out_q <= valid_out_d;
      valid_ap_q  <= valid_ap_d;
      done_q      <= done_d;
    end
  end

  assign bit_ready     = (state_q == D_SYS);
  assign idle          = (state_q == IDLE);
  assign out           = out_q;
  assign valid_out     = valid_out_q;
  assign apriori       = apriori_q;
  assign valid_apriori = valid_ap_q;
  assign done          = done_q;

endmodule

// File: tb/tb_siso_stream_gen.sv
// Scoreboard bench for siso_stream_gen: a block-level reference model queues
// the expected sample stream, a negedge monitor pops and compares it.
module tb_siso_stream_gen;

  localparam int DW   = 16;
  localparam int AMP  = 1024;
  localparam int MAXK = 6144;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [12:0]   blklen = '0;
  logic          bit_in = 1'b0;
  logic [DW-1:0] apriori_in = '0;
  logic          bit_valid = 1'b0;
  logic          bit_ready;
  logic [DW-1:0] out;
  logic          valid_out;
  logic [DW-1:0] apriori;
  logic          valid_apriori;
  logic          idle;
  logic          done;

  siso_stream_gen #(.DATA_W(DW), .AMP(AMP), .MAX_BLKLEN(MAXK)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .blklen        (blklen),
    .bit_in        (bit_in),
    .apriori_in    (apriori_in),
    .bit_valid     (bit_valid),
    .bit_ready     (bit_ready),
    .out           (out),
    .valid_out     (valid_out),
    .apriori       (apriori),
    .valid_apriori (valid_apriori),
    .idle          (idle),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] smp;
    logic          va;
    logic [DW-1:0] ap;
  } exp_t;

  exp_t          sb[$];
  logic          blk_bits[$];
  logic [DW-1:0] blk_ap[$];

  int n_tests  = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int smp_cnt  = 0;
  logic [DW-1:0] last_ap = '0;
  logic          prev_vo = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [DW-1:0] lmap(input int b);
    return (b != 0) ? DW'(-AMP) : DW'(AMP);
  endfunction

  // Whole-block reference: integer trellis walk over data plus 3 tail steps.
  task automatic model_block(input int k);
    int s1, s2, s3, u, a, z;
    logic tl;
    s1 = 0; s2 = 0; s3 = 0;
    for (int i = 0; i < k + 3; i++) begin
      tl = (i >= k);
      u  = tl ? (s2 ^ s3) : int'(blk_bits[i]);
      a  = u ^ s2 ^ s3;
      z  = a ^ s1 ^ s3;
      sb.push_back('{lmap(u), 1'b1, tl ? DW'(0) : blk_ap[i]});
      sb.push_back('{lmap(z), 1'b0, DW'(0)});
      s3 = s2; s2 = s1; s1 = a;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      prev_vo = 1'b0;
    end else begin
      if (valid_out) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_sample: got %0h expected none (cycle %0d)", out, cyc);
        end else begin
          e = sb.pop_front();
          chk("out", out, e.smp);
          chk("valid_apriori", valid_apriori, e.va);
          if (e.va) begin
            chk("apriori", apriori, e.ap);
            last_ap = e.ap;
          end else begin
            chk("apriori_hold", apriori, last_ap);
          end
          smp_cnt++;
        end
      end else begin
        chk("va_without_vo", valid_apriori, 1'b0);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_sb_empty", sb.size(), 0);
        chk("done_idle", idle, 1'b1);
        chk("done_no_sample", valid_out, 1'b0);
        chk("done_after_last", prev_vo, 1'b1);
      end
      prev_vo = valid_out;
    end
  end

  task automatic fill_random(input int k);
    blk_bits.delete();
    blk_ap.delete();
    for (int i = 0; i < k; i++) begin
      blk_bits.push_back(1'($urandom_range(1)));
      blk_ap.push_back(DW'($urandom));
    end
  endtask

  task automatic fill_basic();
    blk_bits.delete();
    blk_ap.delete();
    blk_bits.push_back(1'b1); blk_ap.push_back(DW'(7));
    blk_bits.push_back(1'b0); blk_ap.push_back(DW'(-3));
    blk_bits.push_back(1'b0); blk_ap.push_back(DW'(100));
    blk_bits.push_back(1'b0); blk_ap.push_back(DW'(0));
  endtask

  // bubble_pct: chance of bit_valid low per data cycle; restart_at >= 0 pulses a
  // stray start on that data-loop cycle.
  task automatic run_block(input int k_req, input int bubble_pct, input int restart_at);
    int   k, i, budget, d0, s0, stc;
    logic bv, rdy;
    k = (k_req > MAXK) ? MAXK : k_req;
    model_block(k);
    d0 = done_cnt;
    s0 = smp_cnt;
    start  = 1'b1;
    blklen = 13'(k_req);
    @(posedge clk); #1;
    start = 1'b0;
    stc = cyc;
    i = 0;
    budget = 0;
    while (i < k && budget < 40 * k + 100) begin
      bv         = ($urandom_range(99) >= bubble_pct);
      bit_valid  = bv;
      bit_in     = bv ? blk_bits[i] : 1'($urandom);
      apriori_in = bv ? blk_ap[i] : DW'($urandom);
      start      = (restart_at >= 0) && (budget == restart_at);
      blklen     = 13'd5;
      rdy        = bit_ready;
      @(posedge clk); #1;
      if (bv && rdy) i++;
      budget++;
    end
    start = 1'b0;
    chk("data_accept_timeout", i, k);
    budget = 0;
    while (done_cnt == d0 && budget < 200) begin
      bit_valid  = 1'($urandom);
      bit_in     = 1'($urandom);
      apriori_in = DW'($urandom);
      @(posedge clk); #1;
      budget++;
    end
    bit_valid = 1'b0;
    chk("done_count", done_cnt - d0, 1);
    chk("sample_count", smp_cnt - s0, 2 * (k + 3));
    if (bubble_pct == 0 && restart_at < 0 && done_cnt != d0)
      chk("done_latency", done_cyc - stc, 2 * k + 7);
    @(posedge clk); #1;
    chk("idle_after_block", idle, 1'b1);
  endtask

  initial begin
    int d0, s0, i, budget;
    logic rdy;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", out, 0);
    chk("rst_apriori", apriori, 0);
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_valid_apriori", valid_apriori, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_bit_ready", bit_ready, 1'b0);
    chk("rst_idle", idle, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;

    fill_basic();
    run_block(4, 0, -1);
    fill_basic();
    run_block(4, 50, -1);
    blk_bits.delete();
    blk_ap.delete();
    run_block(0, 0, -1);

    // abort after 5 samples
    fill_basic();
    model_block(4);
    d0 = done_cnt;
    s0 = smp_cnt;
    start  = 1'b1;
    blklen = 13'd4;
    @(posedge clk); #1;
    start = 1'b0;
    i = 0;
    budget = 0;
    while (smp_cnt - s0 < 5 && budget < 100) begin
      bit_valid  = (i < 4);
      bit_in     = (i < 4) ? blk_bits[i] : 1'b0;
      apriori_in = (i < 4) ? blk_ap[i] : '0;
      rdy        = bit_ready;
      @(posedge clk); #1;
      if (rdy && i < 4) i++;
      budget++;
    end
    chk("abort_reached_5", smp_cnt - s0, 5);
    rst = 1'b1;
    #1;
    chk("abort_out", out, 0);
    chk("abort_apriori", apriori, 0);
    chk("abort_valid_out", valid_out, 1'b0);
    chk("abort_valid_apriori", valid_apriori, 1'b0);
    chk("abort_bit_ready", bit_ready, 1'b0);
    chk("abort_idle", idle, 1'b1);
    sb.delete();
    last_ap = '0;
    bit_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, d0);
    chk("abort_stays_idle", idle, 1'b1);

    fill_basic();
    run_block(4, 0, -1);

    fill_random(MAXK);
    run_block(8000, 0, 100);

    for (int n = 0; n < 12; n++) begin
      int kk;
      kk = $urandom_range(40);
      fill_random(kk);
      run_block(kk, (n % 3 == 0) ? 0 : $urandom_range(70), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
